// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sprite ROM read arbiter with latency-tracked response routing
// Optional build macro: SPRITE_ARB_PRIO0_EN (requester 0 gets absolute priority).
module sprite_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    busy
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              vld_q [RD_LAT];
    logic [IDX_W-1:0]  id_q  [RD_LAT];

    logic [N_REQ-1:0]  rr_req;
    logic [N_REQ-1:0]  masked;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;

    // Requests at or above ptr win first; otherwise wrap to the lowest asserted request.
    always_comb begin
        rr_req = req;
`ifdef SPRITE_ARB_PRIO0_EN
        rr_req[0] = 1'b0;
`endif
        masked  = rr_req & ~((N_REQ'(1) << ptr_q) - N_REQ'(1));
        gnt_any = |rr_req;
        gnt_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rr_req[i]) gnt_idx = IDX_W'(i);
        end
        if (|masked) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (masked[i]) gnt_idx = IDX_W'(i);
            end
        end
`ifdef SPRITE_ARB_PRIO0_EN
        if (req[0]) begin
            gnt_any = 1'b1;
            gnt_idx = '0;
        end
`endif
        if (!rst_n) gnt_any = 1'b0;

        gnt = '0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
        mem_en   = gnt_any;
        mem_addr = gnt_any ? req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : addr_q;

        ptr_d = ptr_q;
`ifdef SPRITE_ARB_PRIO0_EN
        if (gnt_any && gnt_idx != '0) begin
            ptr_d = (gnt_idx == LAST_IDX) ? IDX_W'(1) : gnt_idx + IDX_W'(1);
        end
`else
        if (gnt_any) begin
            ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            addr_q <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                vld_q[s] <= 1'b0;
                id_q[s]  <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            addr_q   <= mem_addr;
            vld_q[0] <= gnt_any;
            id_q[0]  <= gnt_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                id_q[s]  <= id_q[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (vld_q[RD_LAT-1]) rsp_valid[id_q[RD_LAT-1]] = 1'b1;
        busy = 1'b0;
        for (int s = 0; s < RD_LAT; s++) busy = busy | vld_q[s];
    end

    assign rsp_data = mem_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed vector table plus randomized reference-model check of sprite_rom_arbiter
module tb_sprite_rom_arbiter;
    localparam int N   = 4;
    localparam int AW  = 13;
    localparam int DW  = 12;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            busy;

    sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[11:0] ^ {a[12], a[12:2]} ^ 12'h5A3;
    endfunction

    // ROM stand-in with a fixed LAT-cycle read latency
    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        if (mem_en) rom_pipe[0] <= rom_f(mem_addr);
        for (int s = 1; s < LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
    end
    assign mem_data = rom_pipe[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: pointer plus a list of outstanding reads with due cycles
    typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
    rsp_t pend[$];
    int   m_ptr = 0;
    int   cyc   = 0;

    function automatic int model_pick(input logic [N-1:0] r);
`ifdef SPRITE_ARB_PRIO0_EN
        int start;
        if (r[0]) return 0;
        start = (m_ptr == 0) ? 1 : m_ptr;
        for (int k = 0; k < N - 1; k++) begin
            int i;
            i = 1 + ((start - 1 + k) % (N - 1));
            if (r[i]) return i;
        end
        return -1;
`else
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
`endif
    endfunction

    function automatic void model_grant(input int g);
`ifdef SPRITE_ARB_PRIO0_EN
        if (g != 0) m_ptr = (g + 1 == N) ? 1 : g + 1;
`else
        m_ptr = (g + 1) % N;
`endif
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        pend.delete();
        m_ptr = 0;
    endtask

    typedef struct { logic [N-1:0] rq; logic [N-1:0] g; logic [N-1:0] rv; logic b; } vec_t;
    vec_t vq[$];
    logic [AW-1:0] a_fix [N];
    logic [N-1:0]  rq;
    logic [AW-1:0] ra [N];

    initial begin
        a_fix[0] = 13'h100; a_fix[1] = 13'h101; a_fix[2] = 13'h0A5; a_fix[3] = 13'h103;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = a_fix[i];
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_en", mem_en, 0);

        // Release, then grants at t and t+1 with reset landing at t+1.5
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("release_gnt", gnt, 4'b0001);
        chk("release_mem_addr", mem_addr, 13'h100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_gnt", gnt, 4'b0010);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("midrst_rsp_valid", rsp_valid, 0);
            chk("midrst_busy", busy, 0);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("post_midrst_gnt", gnt, 4'b0001);

        @(posedge clk); #1; req = '0; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;

`ifndef SPRITE_ARB_PRIO0_EN
        vq.push_back('{4'b0100, 4'b0100, 4'b0000, 1'b0});
        vq.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b1});
        vq.push_back('{4'b0000, 4'b0000, 4'b0100, 1'b1});
        vq.push_back('{4'b1111, 4'b1000, 4'b0000, 1'b0});
        vq.push_back('{4'b1111, 4'b0001, 4'b0000, 1'b1});
        vq.push_back('{4'b1111, 4'b0010, 4'b1000, 1'b1});
        vq.push_back('{4'b1111, 4'b0100, 4'b0001, 1'b1});
        vq.push_back('{4'b1111, 4'b1000, 4'b0010, 1'b1});
        vq.push_back('{4'b1111, 4'b0001, 4'b0100, 1'b1});
        vq.push_back('{4'b1111, 4'b0010, 4'b1000, 1'b1});
        vq.push_back('{4'b1111, 4'b0100, 4'b0001, 1'b1});
        vq.push_back('{4'b0000, 4'b0000, 4'b0010, 1'b1});
        vq.push_back('{4'b0000, 4'b0000, 4'b0100, 1'b1});
        vq.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b0});
        vq.push_back('{4'b1000, 4'b1000, 4'b0000, 1'b0});
        vq.push_back('{4'b1010, 4'b0010, 4'b0000, 1'b1});
        vq.push_back('{4'b1000, 4'b1000, 4'b1000, 1'b1});
        vq.push_back('{4'b1010, 4'b0010, 4'b0010, 1'b1});
        vq.push_back('{4'b1000, 4'b1000, 4'b1000, 1'b1});
        vq.push_back('{4'b0000, 4'b0000, 4'b0010, 1'b1});
        vq.push_back('{4'b0000, 4'b0000, 4'b1000, 1'b1});
        foreach (vq[r]) begin
            req = vq[r].rq;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", r), gnt, vq[r].g);
            chk($sformatf("vec%0d_rsp_valid", r), rsp_valid, vq[r].rv);
            chk($sformatf("vec%0d_busy", r), busy, vq[r].b);
            chk($sformatf("vec%0d_mem_en", r), mem_en, |vq[r].g);
            if (vq[r].g != 0) chk($sformatf("vec%0d_mem_addr", r), mem_addr, a_fix[oh_idx(vq[r].g)]);
            if (vq[r].rv != 0) chk($sformatf("vec%0d_rsp_data", r), rsp_data, rom_f(a_fix[oh_idx(vq[r].rv)]));
            @(posedge clk); #1;
        end
`else
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("prio_gnt0", gnt, 4'b0001);
            @(posedge clk); #1;
        end
        req = 4'b0010;
        @(negedge clk);
        chk("prio_gnt1", gnt, 4'b0010);
        @(posedge clk); #1;
`endif

        // Randomized phase against the reference model
        req = '0;
        do_reset();
        rq = '0;
        for (int c = 0; c < 500; c++) begin
            int g;
            logic [N-1:0] exp_rv;
            logic [DW-1:0] exp_d;
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(0, 2) != 0) begin
                    rq[i] = 1'b1;
                    ra[i] = AW'($urandom);
                end
                req_addr[i*AW +: AW] = ra[i];
            end
            req = rq;
            @(negedge clk);
            g = model_pick(rq);
            chk("rnd_gnt", gnt, (g >= 0) ? (32'd1 << g) : 32'd0);
            chk("rnd_mem_en", mem_en, g >= 0);
            if (g >= 0) chk("rnd_mem_addr", mem_addr, ra[g]);
            chk("rnd_busy", busy, pend.size() != 0);
            exp_rv = '0;
            exp_d  = '0;
            while (pend.size() != 0 && pend[0].due == cyc) begin
                exp_rv[pend[0].id] = 1'b1;
                exp_d = pend[0].data;
                void'(pend.pop_front());
            end
            chk("rnd_rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != 0) chk("rnd_rsp_data", rsp_data, exp_d);
            if (g >= 0) begin
                pend.push_back('{cyc + LAT, g, rom_f(ra[g])});
                model_grant(g);
                if ($urandom_range(0, 1) == 0) rq[g] = 1'b0;
                else ra[g] = AW'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin arbiter that shares the single-port sprite block ROM (13-bit address, 12-bit RGB444 data) between several pixel-fetch requesters: fruit renderers, blade trail and background. It accepts at most one read per cycle and drives the ROM address. It tracks each read through the ROM's fixed read latency and returns the data to the requester that issued it, with a one-hot valid strobe. It sits between the render engines and the ROM instance.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 13, ROM address width
- DATA_W, 12, ROM data width
- RD_LAT, 2, ROM clock-to-data latency in cycles (1..4)

Ports:
- clk  in  1  single clock for all logic and the ROM
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester read request, held until granted
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot or zero; read i accepted this cycle
- rsp_valid  out  N_REQ  one-hot or zero; rsp_data belongs to requester i this cycle
- rsp_data  out  DATA_W  ROM read data
- mem_en  out  1  ROM enable / read strobe
- mem_addr  out  ADDR_W  ROM address
- mem_data  in  DATA_W  ROM output
- busy  out  1  any read in flight

## Operation
- Handshake: a transfer occurs in cycle t when req[i] && gnt[i]. The requester keeps req_addr[i] stable while req[i] is high and ungranted. It may drop req[i] only after a grant.
- Arbitration is combinational from req and the registered pointer ptr. The first asserted req at or after ptr, searching upward modulo N_REQ, is granted.
- After a grant to i, ptr <= (i+1) mod N_REQ. With no grant, ptr holds.
- mem_en = |gnt. mem_addr = the granted requester's address. With no grant, mem_addr is held at its last value, which saves ROM toggling.
- Tracking pipeline: shift register of RD_LAT stages, each holding {valid, id[clog2(N_REQ)]}. Stage 0 loads {|gnt, granted index} every cycle.
- rsp_valid[id] = the last stage's valid. rsp_data passes mem_data through combinationally.
- busy = OR of all stage valids.
- Back-to-back grants are allowed every cycle, to the same or different requesters. Throughput is 1 read per clk.
- Reset, asynchronous and also mid-operation: ptr=0; all stages invalid; gnt=0 while rst_n is low; rsp_valid=0; busy=0; mem_addr=0. Reads in flight are dropped with no response.

## Timing
- Grant latency: 0 cycles. gnt is valid in the same cycle as req, provided it wins arbitration.
- Response latency: a read granted in cycle t has rsp_valid asserted in exactly cycle t+RD_LAT, for one cycle.
- No back-pressure on responses. A requester must capture the data in that cycle.
- Fairness: a continuously asserted request is granted within N_REQ cycles (or within N_REQ+... see Configuration for the priority mode).
- ptr wrap-around: after a grant to N_REQ-1, ptr returns to 0.

## Configuration
- SPRITE_ARB_PRIO0_EN defined: requester 0 (background/scan-out) has absolute priority. It is granted whenever req[0]=1, regardless of ptr. Requesters 1..N_REQ-1 round-robin among themselves, and ptr skips 0. Grants to 0 do not move ptr.
- Not defined: pure round-robin across all N_REQ requesters, as described above.

## Test plan
- Reset: assert rst_n=0 with req=4'b1111 -> gnt=0, rsp_valid=0, busy=0, mem_addr=0. Release -> first gnt=4'b0001.
- Single read: req[2] with addr 13'h0A5 at cycle t -> gnt[2] at t, mem_addr=13'h0A5, mem_en=1. rsp_valid=4'b0100 at t+2 with rsp_data equal to the ROM word at 0x0A5.
- Full contention: all four req held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order, each 2 cycles after its grant, with no gaps.
- Pointer fairness: req[3] always high and req[1] pulsed -> req[1] is granted no later than the 2nd cycle after it asserts. Grants alternate between 3 and 1.
- Mid-flight reset: grants at t and t+1, then rst_n=0 at t+1.5 -> no rsp_valid at t+2 or t+3. After release, ptr=0.
- SPRITE_ARB_PRIO0_EN: req[0] and req[1] held high together -> gnt[0] every cycle and req[1] starves. Drop req[0] -> gnt[1] the next cycle.
